vga_text_renderer: RTL and testbench

- Downstream of the VGA timing counter stage. Consumes the pixel strobe, pixel/line counts and raw syncs; produces the 8-bit pixel colour plus re-aligned syncs for the VGA pins.
- Holds an 80x30 character buffer, writable from a host port, and an 8x16 glyph ROM.
- Renders a 640x480 text screen through a 3-stage pipeline that advances only on the pixel strobe.

---
 rtl/vga_text_pkg.sv | 47 ++++
 rtl/vga_font_rom.sv | 18 +
 rtl/vga_text_renderer.sv | 146 ++++++++++++++
 tb/tb_vga_text_renderer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vga_text_pkg.sv
// Shared constants, character cell type and font contents for the VGA text renderer.
package vga_text_pkg;

  localparam int COLS        = 80;
  localparam int ROWS        = 30;
  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int GLYPH_W     = 8;
  localparam int GLYPH_H     = 16;
  localparam int FX_W        = $clog2(GLYPH_W);
  localparam int FY_W        = $clog2(GLYPH_H);
  localparam int CELLS       = COLS * ROWS;
  localparam int ADDR_W      = 12;
  localparam int FULL_ADDR_W = 14;
  localparam int ROM_ADDR_W  = 11;

  typedef struct packed {
    logic       inv;
    logic [6:0] glyph;
  } char_cell_t;

  // Font image: {glyph[6:0], row[3:0]} -> 8 pixels, column 0 in bit 7.
  function automatic logic [7:0] font_row(input logic [ROM_ADDR_W-1:0] a);
    logic [7:0] row_s;
    case (a[10:4])
      7'h41: begin
        case (a[3:0])
          4'd2:    row_s = 8'h18;
          4'd3:    row_s = 8'h3C;
          4'd4:    row_s = 8'h66;
          4'd5:    row_s = 8'hC3;
          4'd6:    row_s = 8'hC3;
          4'd7:    row_s = 8'hFF;
          4'd8:    row_s = 8'hC3;
          4'd9:    row_s = 8'hC3;
          4'd10:   row_s = 8'hC3;
          4'd11:   row_s = 8'hC3;
          default: row_s = 8'h00;
        endcase
      end
      7'h7F:   row_s = 8'hFF;
      default: row_s = 8'h00;
    endcase
    return row_s;
  endfunction

endpackage

// File: rtl/vga_font_rom.sv
// Synchronous 2048x8 glyph ROM with one registered read port enabled by the pixel strobe.
module vga_font_rom
  import vga_text_pkg::*;
(
  input  logic                  clk,
  input  logic                  en,
  input  logic [ROM_ADDR_W-1:0] addr,
  output logic [7:0]            data
);

  // Registered read; contents are constant so no reset is needed.
  always_ff @(posedge clk) begin
    if (en) begin
      data <= font_row(addr);
    end
  end

endmodule

// File: rtl/vga_text_renderer.sv
// 80x30 text-mode renderer: character RAM -> glyph ROM -> pixel colour, 3 strobes deep.
// Optional underline cursor with frame-counter blink when CURSOR_BLINK_EN is defined.
module vga_text_renderer
  import vga_text_pkg::*;
#(
  parameter logic [7:0] FG_COLOR = 8'hFF,
  parameter logic [7:0] BG_COLOR = 8'h00
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        line_y,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
`ifdef CURSOR_BLINK_EN
  input  logic [ADDR_W-1:0] cursor_addr,
  input  logic              cursor_on,
`endif
  output logic              hsync_out,
  output logic              vsync_out,
  output logic [7:0]        color_out
);

  logic [7:0]             ram_r [CELLS];
  logic [FULL_ADDR_W-1:0] addr_full_s;
  logic [ADDR_W-1:0]      addr_s;
  logic [ADDR_W-1:0]      rd_addr_s;
  logic                   active_s;
  logic                   cur_hit_s;
  char_cell_t             char_r;
  logic                   active0_r, hs0_r, vs0_r, cur0_r;
  logic [FX_W-1:0]        frac_x0_r;
  logic [FY_W-1:0]        frac_y0_r;
  logic                   active1_r, hs1_r, vs1_r, cur1_r, inv1_r;
  logic [FX_W-1:0]        frac_x1_r;
  logic [7:0]             glyph_s;
  logic                   pix_bit_s;
  logic [7:0]             color_s;

  // S0 address and visibility; out-of-range reads fall back to entry 0.
  always_comb begin
    addr_full_s = FULL_ADDR_W'(line_y[9:FY_W]) * FULL_ADDR_W'(COLS) + FULL_ADDR_W'(pixel_x[9:FX_W]);
    addr_s      = addr_full_s[ADDR_W-1:0];
    active_s    = (pixel_x < 10'(H_ACTIVE)) && (line_y < 10'(V_ACTIVE));
    if (addr_s < ADDR_W'(CELLS)) begin
      rd_addr_s = addr_s;
    end else begin
      rd_addr_s = {ADDR_W{1'b0}};
    end
  end

`ifdef CURSOR_BLINK_EN
  logic [5:0] frame_cnt_r;
  logic       vs_prev_r;

  // Frame counter counts vsync falling edges seen on the pixel strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_r <= 6'd0;
      vs_prev_r   <= 1'b1;
    end else if (pix_en) begin
      vs_prev_r <= vsync_in;
      if (vs_prev_r && !vsync_in) begin
        frame_cnt_r <= frame_cnt_r + 6'd1;
      end
    end
  end

  assign cur_hit_s = cursor_on && frame_cnt_r[5] && (addr_s == cursor_addr)
                     && (line_y[FY_W-1:0] >= 4'd14);
`else
  assign cur_hit_s = 1'b0;
`endif

  // Character RAM: host writes every clk, read-first pipeline read on the strobe.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < ADDR_W'(CELLS))) begin
      ram_r[wr_addr] <= wr_data;
    end
    if (pix_en) begin
      char_r <= char_cell_t'(ram_r[rd_addr_s]);
    end
  end

  vga_font_rom u_font_rom (
    .clk  (clk),
    .en   (pix_en),
    .addr ({char_r.glyph, frac_y0_r}),
    .data (glyph_s)
  );

  // S2 colour selection; column 0 is the glyph MSB.
  always_comb begin
    pix_bit_s = glyph_s[3'd7 - frac_x1_r] ^ inv1_r;
    if (!active1_r) begin
      color_s = 8'h00;
    end else if (cur1_r || pix_bit_s) begin
      color_s = FG_COLOR;
    end else begin
      color_s = BG_COLOR;
    end
  end

  // Pipeline stages S0..S2 and the matching sync delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active0_r <= 1'b0;
      hs0_r     <= 1'b1;
      vs0_r     <= 1'b1;
      cur0_r    <= 1'b0;
      frac_x0_r <= {FX_W{1'b0}};
      frac_y0_r <= {FY_W{1'b0}};
      active1_r <= 1'b0;
      hs1_r     <= 1'b1;
      vs1_r     <= 1'b1;
      cur1_r    <= 1'b0;
      inv1_r    <= 1'b0;
      frac_x1_r <= {FX_W{1'b0}};
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      color_out <= 8'h00;
    end else if (pix_en) begin
      active0_r <= active_s;
      hs0_r     <= hsync_in;
      vs0_r     <= vsync_in;
      cur0_r    <= cur_hit_s;
      frac_x0_r <= pixel_x[FX_W-1:0];
      frac_y0_r <= line_y[FY_W-1:0];
      active1_r <= active0_r;
      hs1_r     <= hs0_r;
      vs1_r     <= vs0_r;
      cur1_r    <= cur0_r;
      inv1_r    <= char_r.inv;
      frac_x1_r <= frac_x0_r;
      hsync_out <= hs1_r;
      vsync_out <= vs1_r;
      color_out <= color_s;
    end
  end

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed self-checking bench for vga_text_renderer (cursor checks built when CURSOR_BLINK_EN is defined).
module tb_vga_text_renderer;
  import vga_text_pkg::*;

  logic        clk = 1'b0;
  logic        rst, pix_en, hsync_in, vsync_in, wr_en;
  logic [9:0]  pixel_x, line_y;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        hsync_out, vsync_out;
  logic [7:0]  color_out;
`ifdef CURSOR_BLINK_EN
  logic [11:0] cursor_addr;
  logic        cursor_on;
`endif

  int checks = 0;
  int errors = 0;

  // Expected outputs of the last three strobes; entry 2 is due at the outputs now.
  logic [7:0] e_col [3];
  logic       e_hs  [3];
  logic       e_vs  [3];

  localparam logic [7:0] A_ROW0 = 8'h00;
  localparam logic [7:0] A_ROW2 = 8'h18;
  localparam logic [7:0] A_ROW5 = 8'hC3;

  vga_text_renderer dut (
    .clk       (clk),
    .rst       (rst),
    .pix_en    (pix_en),
    .pixel_x   (pixel_x),
    .line_y    (line_y),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`ifdef CURSOR_BLINK_EN
    .cursor_addr (cursor_addr),
    .cursor_on   (cursor_on),
`endif
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .color_out (color_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] px(input logic [7:0] row, input int x);
    return row[7 - x] ? 8'hFF : 8'h00;
  endfunction

  task automatic fill_reset();
    for (int i = 0; i < 3; i++) begin
      e_col[i] = 8'h00;
      e_hs[i]  = 1'b1;
      e_vs[i]  = 1'b1;
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One strobe, one idle cycle, then check the outputs against the sample from two strobes ago.
  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic hs, input logic vs,
                      input logic [7:0] col, input string tag,
                      input logic do_wr = 1'b0, input logic [11:0] wa = 12'd0,
                      input logic [7:0] wd = 8'h00);
    @(negedge clk);
    pixel_x = x; line_y = y; hsync_in = hs; vsync_in = vs; pix_en = 1'b1;
    wr_en = do_wr; wr_addr = wa; wr_data = wd;
    e_col[2] = e_col[1]; e_col[1] = e_col[0]; e_col[0] = col;
    e_hs[2]  = e_hs[1];  e_hs[1]  = e_hs[0];  e_hs[0]  = hs;
    e_vs[2]  = e_vs[1];  e_vs[1]  = e_vs[0];  e_vs[0]  = vs;
    @(negedge clk);
    pix_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    check({tag, "_col"}, color_out, e_col[2]);
    check({tag, "_hs"}, {7'd0, hsync_out}, {7'd0, e_hs[2]});
    check({tag, "_vs"}, {7'd0, vsync_out}, {7'd0, e_vs[2]});
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    wr_en = 1'b0; wr_addr = 12'd0; wr_data = 8'h00; pixel_x = 10'd0; line_y = 10'd0;
`ifdef CURSOR_BLINK_EN
    cursor_addr = 12'd0; cursor_on = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_col", color_out, 8'h00);
    check("rst_hs", {7'd0, hsync_out}, 8'h01);
    check("rst_vs", {7'd0, vsync_out}, 8'h01);
    rst = 1'b0;
    fill_reset();

    wr(12'd0, 8'h41);
    wr(12'd81, 8'hC1);

    // Vertical sync alignment in blanking.
    for (int i = 0; i < 3; i++) step(10'd700, 10'd490, 1'b1, 1'b0, 8'h00, "vs_low");
    for (int i = 0; i < 3; i++) step(10'd700, 10'd490, 1'b1, 1'b1, 8'h00, "vs_high");

    // Bring outputs away from reset values, then reset asynchronously mid-line.
    for (int x = 0; x < 3; x++) step(10'(x), 10'd5, 1'b0, 1'b1, px(A_ROW5, x), "pre_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_col", color_out, 8'h00);
    check("async_rst_hs", {7'd0, hsync_out}, 8'h01);
    check("async_rst_vs", {7'd0, vsync_out}, 8'h01);
    @(negedge clk);
    rst = 1'b0;
    fill_reset();

    // Glyph 'A' row 5; first two checks see the flushed pipeline.
    for (int x = 0; x < 8; x++) step(10'(x), 10'd5, 1'b1, 1'b1, px(A_ROW5, x), "glyph");
    // Inverse video cell 81.
    for (int x = 0; x < 8; x++) step(10'(8 + x), 10'd21, 1'b1, 1'b1, ~px(A_ROW5, x), "inv_r5");
    for (int x = 0; x < 8; x++) step(10'(8 + x), 10'd16, 1'b1, 1'b1, ~px(A_ROW0, x), "inv_r0");
    for (int x = 0; x < 8; x++) step(10'(8 + x), 10'd18, 1'b1, 1'b1, ~px(A_ROW2, x), "inv_r2");
    step(10'd15, 10'd31, 1'b1, 1'b1, 8'hFF, "inv_r15");

    // Blanking forces colour to zero.
    step(10'd640, 10'd5,   1'b1, 1'b1, 8'h00, "blank_x640");
    step(10'd700, 10'd5,   1'b1, 1'b1, 8'h00, "blank_x700");
    step(10'd799, 10'd5,   1'b1, 1'b1, 8'h00, "blank_x799");
    step(10'd0,   10'd480, 1'b1, 1'b1, 8'h00, "blank_y480");
    step(10'd0,   10'd524, 1'b1, 1'b1, 8'h00, "blank_y524");

    // 96-strobe hsync pulse, checked strobe by strobe with a 3-strobe delay.
    for (int i = 0; i < 96; i++) step(10'(656 + i), 10'd5, 1'b0, 1'b1, 8'h00, "hs_pulse");
    for (int i = 0; i < 4; i++) step(10'(752 + i), 10'd5, 1'b1, 1'b1, 8'h00, "hs_end");

    // Out-of-range write must not touch cell 0.
    wr(12'd2400, 8'h7F);
    for (int x = 0; x < 8; x++) step(10'(x), 10'd5, 1'b1, 1'b1, px(A_ROW5, x), "oob_wr");

    // Write and read of cell 0 in the same cycle renders the old glyph.
    step(10'd2, 10'd5, 1'b1, 1'b1, 8'h00, "rw_old", 1'b1, 12'd0, 8'h7F);
    step(10'd2, 10'd5, 1'b1, 1'b1, 8'hFF, "rw_new");
    step(10'd700, 10'd5, 1'b1, 1'b1, 8'h00, "flush");
    step(10'd700, 10'd5, 1'b1, 1'b1, 8'h00, "flush");

`ifdef CURSOR_BLINK_EN
    wr(12'd0, 8'h41);
    cursor_addr = 12'd0;
    cursor_on   = 1'b1;
    step(10'd2, 10'd14, 1'b1, 1'b1, 8'h00, "cur_off0");
    for (int i = 0; i < 32; i++) begin
      step(10'd700, 10'd490, 1'b1, 1'b0, 8'h00, "cur_vfall");
      step(10'd700, 10'd490, 1'b1, 1'b1, 8'h00, "cur_vrise");
    end
    step(10'd2, 10'd14, 1'b1, 1'b1, 8'hFF, "cur_on14");
    step(10'd3, 10'd15, 1'b1, 1'b1, 8'hFF, "cur_on15");
    step(10'd2, 10'd5,  1'b1, 1'b1, 8'h00, "cur_row5");
    for (int i = 0; i < 32; i++) begin
      step(10'd700, 10'd490, 1'b1, 1'b0, 8'h00, "cur_vfall2");
      step(10'd700, 10'd490, 1'b1, 1'b1, 8'h00, "cur_vrise2");
    end
    step(10'd2, 10'd14, 1'b1, 1'b1, 8'h00, "cur_off1");
    step(10'd700, 10'd5, 1'b1, 1'b1, 8'h00, "cur_flush");
    step(10'd700, 10'd5, 1'b1, 1'b1, 8'h00, "cur_flush");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
